// File: rtl/rr_stream_merge_2_pkg.sv
// Shared definitions for the two-input round-robin stream merger.
// Holds the source-index width and the default-width beat payload layout.
package rr_stream_merge_2_pkg;

    localparam int unsigned SRC_W     = 1;
    localparam int unsigned DEF_WIDTH = 8;

    // Beat payload at the default data width; modules with a different
    // WIDTH declare a local struct with the same field order.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] data;
        logic                 last;
        logic [SRC_W-1:0]     src;
    } beat_t;

endpackage

// File: rtl/rr_stream_merge_2_skid_reg.sv
// Valid/ready register slice with a one-entry skid buffer.
// Ports:
//   clk, rst                    clock, async active-high reset
//   in_valid/in_ready/in_data   upstream side; in_ready is a pure register
//   out_valid/out_ready/out_data downstream side, fully registered
// Sustains one beat per cycle with no combinational out_ready->in_ready path.
module stream_skid_reg #(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid;
    logic [W-1:0] main_data;
    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         accept;

    assign in_ready  = ~skid_valid;
    assign accept    = in_valid && ~skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    // Skid only fills when main is stalled; accept and skid drain are exclusive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else begin
            if (skid_valid && out_ready) begin
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end else if (accept && (!main_valid || out_ready)) begin
                main_valid <= 1'b1;
                main_data  <= in_data;
            end else if (accept) begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
            end else if (main_valid && out_ready) begin
                main_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rr_stream_merge_2.sv
// Two-input valid/ready stream merger with packet-granular round-robin.
// Ports:
//   clk, rst                         clock, async active-high reset
//   in0_valid/ready/data/last        source 0 stream
//   in1_valid/ready/data/last        source 1 stream
//   out_valid/ready/data/last/src    merged stream, registered via skid slice
// A packet, once its first beat is accepted, owns the output until its last
// beat; ties between packet starts alternate, source 0 winning after reset.
module rr_stream_merge_2
    import rr_stream_merge_2_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_src
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
        logic [SRC_W-1:0] src;
    } beat_l_t;

    localparam int unsigned BEAT_W = $bits(beat_l_t);

    logic             lock;
    logic [SRC_W-1:0] lock_src;
    logic [SRC_W-1:0] last_src;

    logic [SRC_W-1:0] sel;
    logic             sel_valid;
    logic             sel_last;
    logic [WIDTH-1:0] sel_data;
    logic             slice_ready;
    logic             take;
    beat_l_t          in_beat;
    beat_l_t          out_beat;

    // Source selection: held by an open packet, otherwise round-robin on ties.
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        if (lock) begin
            sel       = lock_src;
            sel_valid = (lock_src == SRC_W'(1)) ? in1_valid : in0_valid;
        end else if (in0_valid && in1_valid) begin
            sel       = ~last_src;
            sel_valid = 1'b1;
        end else if (in0_valid) begin
            sel       = SRC_W'(0);
            sel_valid = 1'b1;
        end else if (in1_valid) begin
            sel       = SRC_W'(1);
            sel_valid = 1'b1;
        end
    end

    assign sel_last = (sel == SRC_W'(1)) ? in1_last : in0_last;
    assign sel_data = (sel == SRC_W'(1)) ? in1_data : in0_data;

    // Nothing is accepted while reset is held.
    assign take      = sel_valid && slice_ready && !rst;
    assign in0_ready = take && (sel == SRC_W'(0));
    assign in1_ready = take && (sel == SRC_W'(1));

    // Packet lock and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock     <= 1'b0;
            lock_src <= '0;
            last_src <= SRC_W'(1);
        end else if (take) begin
            if (sel_last) begin
                lock     <= 1'b0;
                last_src <= sel;
            end else begin
                lock     <= 1'b1;
                lock_src <= sel;
            end
        end
    end

    assign in_beat.data = sel_data;
    assign in_beat.last = sel_last;
    assign in_beat.src  = sel;

    stream_skid_reg #(
        .W (BEAT_W)
    ) u_out_slice (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (sel_valid && !rst),
        .in_ready  (slice_ready),
        .in_data   (in_beat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_beat)
    );

    assign out_data = out_beat.data;
    assign out_last = out_beat.last;
    assign out_src  = out_beat.src;

endmodule
